morse_decoder: RTL and testbench

Receive-side Morse decoder, the counterpart of the keyer/transmitter. It samples a keyed on/off line and times each mark and space in dot-unit ticks, using an internal mod-TICK_DIV prescaler. Each mark is classified as dot or dash and accumulated into a character. Completed characters and word gaps are emitted as one-cycle strobes to the downstream character lookup/display logic.

---
 rtl/morse_decoder.sv | 187 ++++++++++++++++++
 tb/tb_morse_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Receive-side Morse decoder: times marks/spaces of a keyed line in dot-unit ticks
// and emits completed characters and word gaps as one-cycle strobes.
//
// state | meaning
// IDLE  | line quiet, waiting for the first mark of a word
// MARK  | tone present, timing the current element
// SPACE | inter-element gap, character still open
// GAP   | character emitted, waiting for a new mark or a word gap
module morse_decoder #(
  parameter int TICK_DIV     = 50000,
  parameter int DASH_MIN     = 2,
  parameter int CHAR_GAP_MIN = 2,
  parameter int WORD_GAP_MIN = 5,
  parameter int MAX_ELEM     = 5
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          key_in,
  output logic                          char_valid,
  output logic [MAX_ELEM-1:0]           char_bits,
  output logic [$clog2(MAX_ELEM+1)-1:0] char_len,
  output logic                          char_err,
  output logic                          word_valid,
  output logic                          busy
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int DUR_W = $clog2(WORD_GAP_MIN + 1);
  localparam int LEN_W = $clog2(MAX_ELEM + 1);

  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_SAT    = DUR_W'(WORD_GAP_MIN);
  localparam logic [DUR_W-1:0] CHAR_LAST  = DUR_W'(CHAR_GAP_MIN - 1);
  localparam logic [DUR_W-1:0] WORD_LAST  = DUR_W'(WORD_GAP_MIN - 1);
  localparam logic [DUR_W:0]   DASH_TICKS = (DUR_W + 1)'(DASH_MIN);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(MAX_ELEM);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2,
    GAP   = 2'd3
  } state_t;

  logic                sync1_q;
  logic                key_s_q;
  logic                key_prev_q;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  state_t              state_q, state_d;
  logic [MAX_ELEM-1:0] elem_q, elem_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                ovf_q, ovf_d;
  logic                char_valid_q, char_valid_d;
  logic [MAX_ELEM-1:0] char_bits_q, char_bits_d;
  logic [LEN_W-1:0]    char_len_q, char_len_d;
  logic                char_err_q, char_err_d;
  logic                word_valid_q, word_valid_d;
  logic                busy_q, busy_d;

  logic             rise;
  logic             fall;
  logic             key_edge;
  logic             wrap;
  logic             tick;
  logic [DUR_W:0]   mark_ticks;
  logic             is_dash;

  assign rise     = key_s_q & ~key_prev_q;
  assign fall     = ~key_s_q & key_prev_q;
  assign key_edge = rise | fall;
  assign wrap     = (presc_q == PRE_LAST);
  assign tick     = wrap & ~key_edge;

  // A tick landing on the falling edge still belongs to the mark, so a mark of
  // exactly DASH_MIN units classifies as a dash even though the edge wins dur.
  assign mark_ticks = {1'b0, dur_q} + {{DUR_W{1'b0}}, wrap};
  assign is_dash    = (mark_ticks >= DASH_TICKS);

  always_comb begin
    presc_d      = (key_edge || wrap) ? '0 : presc_q + PRE_W'(1);
    dur_d        = dur_q;
    state_d      = state_q;
    elem_d       = elem_q;
    len_d        = len_q;
    ovf_d        = ovf_q;
    char_valid_d = 1'b0;
    char_bits_d  = char_bits_q;
    char_len_d   = char_len_q;
    char_err_d   = char_err_q;
    word_valid_d = 1'b0;

    if (key_edge) begin
      dur_d = '0;
    end else if (tick && (dur_q != DUR_SAT)) begin
      dur_d = dur_q + DUR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (rise) state_d = MARK;
      end
      MARK: begin
        if (fall) begin
          if (len_q < LEN_MAX) begin
            for (int i = 0; i < MAX_ELEM; i++) begin
              if (len_q == LEN_W'(i)) elem_d[i] = is_dash;
            end
            len_d = len_q + LEN_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
          state_d = SPACE;
        end
      end
      SPACE: begin
        if (rise) begin
          state_d = MARK;
        end else if (tick && (dur_q == CHAR_LAST)) begin
          char_valid_d = 1'b1;
          char_bits_d  = elem_q;
          char_len_d   = len_q;
          char_err_d   = ovf_q;
          elem_d       = '0;
          len_d        = '0;
          ovf_d        = 1'b0;
          state_d      = GAP;
        end
      end
      GAP: begin
        if (rise) begin
          state_d = MARK;
        end else if (tick && (dur_q == WORD_LAST)) begin
          word_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      sync1_q      <= 1'b0;
      key_s_q      <= 1'b0;
      key_prev_q   <= 1'b0;
      presc_q      <= '0;
      dur_q        <= '0;
      state_q      <= IDLE;
      elem_q       <= '0;
      len_q        <= '0;
      ovf_q        <= 1'b0;
      char_valid_q <= 1'b0;
      char_bits_q  <= '0;
      char_len_q   <= '0;
      char_err_q   <= 1'b0;
      word_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= key_in;
      key_s_q      <= sync1_q;
      key_prev_q   <= key_s_q;
      presc_q      <= presc_d;
      dur_q        <= dur_d;
      state_q      <= state_d;
      elem_q       <= elem_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      char_valid_q <= char_valid_d;
      char_bits_q  <= char_bits_d;
      char_len_q   <= char_len_d;
      char_err_q   <= char_err_d;
      word_valid_q <= word_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign char_valid = char_valid_q;
  assign char_bits  = char_bits_q;
  assign char_len   = char_len_q;
  assign char_err   = char_err_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: a duration-based model checked every cycle, plus
// hand-decoded characters for each directed keying pattern.
module tb_morse_decoder;
  localparam int T  = 4;
  localparam int DM = 2;
  localparam int CG = 2;
  localparam int WG = 5;
  localparam int ME = 5;

  logic       clk = 1'b0;
  logic       areset;
  logic       key_in;
  logic       char_valid;
  logic [4:0] char_bits;
  logic [2:0] char_len;
  logic       char_err;
  logic       word_valid;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  morse_decoder #(
    .TICK_DIV(T), .DASH_MIN(DM), .CHAR_GAP_MIN(CG), .WORD_GAP_MIN(WG), .MAX_ELEM(ME)
  ) dut (
    .clk(clk), .areset(areset), .key_in(key_in),
    .char_valid(char_valid), .char_bits(char_bits), .char_len(char_len),
    .char_err(char_err), .word_valid(word_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int enc(logic [4:0] b, int len, bit err);
    return (int'(err) << 8) | (len << 5) | int'(b);
  endfunction

  function automatic int outs();
    return int'({char_valid, char_bits, char_len, char_err, word_valid, busy});
  endfunction

  task automatic check_eq(string nm, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
  endtask

  // Model: counts cycles since the last synchronized edge; a tick falls on
  // every multiple of T, and a mark lasting n cycles spans n/T ticks.
  logic [2:0] kh;
  int         n;
  int         m_st;          // 0 idle, 1 mark, 2 space, 3 gap
  bit         m_elems[$];
  bit         m_ovf;
  logic       exp_cv, exp_err, exp_wv, exp_busy;
  logic [4:0] exp_bits;
  logic [2:0] exp_len;
  int         dut_log[$];
  int         mdl_log[$];
  int         dut_words = 0;
  int         mdl_words = 0;
  bit         m_rise, m_fall;
  logic [4:0] m_b;

  initial begin
    kh = '0; n = 1; m_st = 0; m_ovf = 0;
    exp_cv = 0; exp_err = 0; exp_wv = 0; exp_busy = 0; exp_bits = '0; exp_len = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!areset) begin
        check_eq("reset_outputs", outs(), 0);
        kh = '0; n = 1; m_st = 0; m_ovf = 0; m_elems.delete();
        exp_cv = 0; exp_err = 0; exp_wv = 0; exp_busy = 0; exp_bits = '0; exp_len = '0;
      end else begin
        check_eq("cycle_outputs", outs(),
                 int'({exp_cv, exp_bits, exp_len, exp_err, exp_wv, exp_busy}));
        if (char_valid) dut_log.push_back(enc(char_bits, int'(char_len), char_err));
        if (word_valid) dut_words++;

        kh     = {kh[1:0], key_in};
        m_rise = kh[1] & ~kh[2];
        m_fall = ~kh[1] & kh[2];
        n++;
        exp_cv = 0;
        exp_wv = 0;
        if (m_rise || m_fall) begin
          if (m_rise && m_st != 1) m_st = 1;
          else if (m_fall && m_st == 1) begin
            if (m_elems.size() < ME) m_elems.push_back((n / T) >= DM);
            else m_ovf = 1;
            m_st = 2;
          end
          n = 0;
        end else if (n % T == 0) begin
          if (m_st == 2 && n / T == CG) begin
            m_b = '0;
            foreach (m_elems[i]) m_b[i] = m_elems[i];
            exp_cv   = 1;
            exp_bits = m_b;
            exp_len  = 3'(m_elems.size());
            exp_err  = m_ovf;
            mdl_log.push_back(enc(m_b, m_elems.size(), m_ovf));
            m_elems.delete();
            m_ovf = 0;
            m_st  = 3;
          end else if (m_st == 3 && n / T == WG) begin
            exp_wv = 1;
            mdl_words++;
            m_st = 0;
          end
        end
        exp_busy = (m_st != 0);
      end
    end
  end

  task automatic pulse(bit v, int cyc);
    key_in = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic expect_chars(string nm, int bc, int bdw, int bmw, int nexp, int e0, int e1);
    check_eq({nm, "_nchar"}, dut_log.size() - bc, nexp);
    check_eq({nm, "_model_nchar"}, mdl_log.size() - bc, nexp);
    if (nexp > 0) begin
      check_eq({nm, "_char0"}, (dut_log.size() > bc) ? dut_log[bc] : -1, e0);
      check_eq({nm, "_model_char0"}, (mdl_log.size() > bc) ? mdl_log[bc] : -1, e0);
    end
    if (nexp > 1) begin
      check_eq({nm, "_char1"}, (dut_log.size() > bc + 1) ? dut_log[bc + 1] : -1, e1);
      check_eq({nm, "_model_char1"}, (mdl_log.size() > bc + 1) ? mdl_log[bc + 1] : -1, e1);
    end
    check_eq({nm, "_words"}, dut_words - bdw, (nexp > 0) ? 1 : 0);
    check_eq({nm, "_model_words"}, mdl_words - bmw, (nexp > 0) ? 1 : 0);
  endtask

  int bc, bdw, bmw;

  task automatic snap();
    bc  = dut_log.size();
    bdw = dut_words;
    bmw = mdl_words;
  endtask

  initial begin
    areset = 1'b0;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_state", outs(), 0);
    areset = 1'b1;
    repeat (8) @(negedge clk);

    // "A": dot, dash
    snap();
    pulse(1, 4); pulse(0, 4); pulse(1, 12); pulse(0, 40);
    expect_chars("A", bc, bdw, bmw, 1, enc(5'b00010, 2, 0), 0);
    check_eq("A_busy_end", int'(busy), 0);

    // "S" then "O" with a 3-unit character gap
    snap();
    for (int i = 0; i < 3; i++) begin pulse(1, 4); pulse(0, (i == 2) ? 12 : 4); end
    for (int i = 0; i < 3; i++) begin pulse(1, 12); pulse(0, (i == 2) ? 40 : 4); end
    expect_chars("SO", bc, bdw, bmw, 2, enc(5'b00000, 3, 0), enc(5'b00111, 3, 0));

    // six dots overflow, then "E" decodes clean
    snap();
    for (int i = 0; i < 6; i++) begin pulse(1, 4); pulse(0, (i == 5) ? 12 : 4); end
    pulse(1, 4); pulse(0, 40);
    expect_chars("OVF", bc, bdw, bmw, 2, enc(5'b00000, 5, 1), enc(5'b00000, 1, 0));

    snap();
    pulse(1, 8); pulse(0, 40);
    expect_chars("DASH_EXACT", bc, bdw, bmw, 1, enc(5'b00001, 1, 0), 0);

    snap();
    pulse(1, 7); pulse(0, 40);
    expect_chars("DOT_SHORT", bc, bdw, bmw, 1, enc(5'b00000, 1, 0), 0);

    // rise lands on the CHAR_GAP_MIN tick: same character continues
    snap();
    pulse(1, 4); pulse(0, 8); pulse(1, 12); pulse(0, 40);
    expect_chars("GAP_TIE", bc, bdw, bmw, 1, enc(5'b00010, 2, 0), 0);

    snap();
    pulse(1, 2); pulse(0, 40);
    expect_chars("SUBTICK", bc, bdw, bmw, 1, enc(5'b00000, 1, 0), 0);

    // reset during the dash of "A"
    snap();
    pulse(1, 4); pulse(0, 4); pulse(1, 6);
    areset = 1'b0;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_mid_during", outs(), 0);
    areset = 1'b1;
    pulse(0, 40);
    expect_chars("RST_MID", bc, bdw, bmw, 0, 0, 0);
    check_eq("rst_mid_after", outs(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
